regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (ND/DI/WE) between two writeback requesters:
//  req0 = ALU/immediate path, req1 = load/multi-cycle unit. Each requester has a one-entry
//  holding slot. The arbiter picks one held write per cycle and drives the write port from
//  registers. It also exports a pending-write mask so decode can interlock on unwritten registers.
// PARAMETERS
//  AW    5   register address width (ND, N1, N2)
//  DW    32  data width (DI)
//  NREG  32  number of architectural registers; width of pend_mask
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     asynchronous, active-high reset
//  req_valid  in   2     per-requester write request
//  req_ready  out  2     per-requester slot can accept this cycle
//  req_nd0    in   AW    req0 destination register
//  req_di0    in   DW    req0 write data
//  req_nd1    in   AW    req1 destination register
//  req_di1    in   DW    req1 write data
//  rf_we      out  1     to regfile WE; registered
//  rf_nd      out  AW    to regfile ND; registered
//  rf_di      out  DW    to regfile DI; registered
//  pend_mask  out  NREG  bit r set = write to r held or on port, not yet committed
// BEHAVIOUR
//  - Interface: one clock (clk); asynchronous, active-high reset (rst).
//  - Reset: hold_v=0, age=0, rr_ptr=0, rf_we=0, rf_nd=0, rf_di=0, pend_mask=0, req_ready=2'b11.
//    Reset mid-operation discards all held and in-flight writes. No partial write is allowed:
//    rf_we drops asynchronously.
//  - Handshake: a write is accepted at the posedge where req_valid[i] & req_ready[i] are both 1.
//    The nd/di values are captured into hold[i].
//  - req_ready[i] = !hold_v[i] | grant[i]. A slot being drained this cycle can refill
//    back-to-back.
//  - Grant (combinational, one per cycle, only among hold_v=1):
//    - If exactly one slot is valid, grant it.
//    - If both are valid, grant the older slot (age tracks fill order).
//    - If both were filled on the same edge: if nd0==nd1, grant req0 first so the req1 value is
//      final; otherwise grant rr_ptr and toggle rr_ptr.
//  - Output stage: on a grant, at the next posedge rf_we=1, rf_nd=hold.nd, rf_di=hold.di.
//    With no grant, rf_we=0 and rf_nd/rf_di hold their values.
//  - The regfile commits on the negedge of that cycle.
//  - Latency: accept edge -> rf_we high one cycle later (minimum); commit half a cycle after that.
//  - Throughput: one write per cycle sustained. Neither requester waits more than one grant
//    while the other is continuously valid.
//  - pend_mask = decode(hold0.nd)&hold_v[0] | decode(hold1.nd)&hold_v[1] | decode(rf_nd)&rf_we.
//    It is combinational from registered state.
//  - The same requester writing the same ND repeatedly is committed in acceptance order.
// CONFIGURATION
//  RF_ZERO_GUARD_EN defined:
//    - A request with nd==0 is accepted (ready as normal) but dropped at grant: it produces no
//      rf_we pulse and does not consume the port cycle.
//    - pend_mask[0] is held at 0.
//  RF_ZERO_GUARD_EN undefined: writes to r0 are forwarded like any other register.
// STRUCTURE
//  Shared package rf_pkg: AW/DW/NREG constants and the wb_req_t struct {nd, di}. The regfile
//  uses these too.
//  One natural sub-module, rf_wb_slot: a single holding register with the ready/fill/drain
//  logic, instantiated twice. Arbitration, age/rr state and the output stage stay in the top.
// TESTING
//  1. Assert rst mid-stream with both slots full -> rf_we=0 and pend_mask=0 immediately;
//     req_ready=2'b11 after release.
//  2. req0 only: nd=5, di=32'h1234 -> next cycle rf_we=1, rf_nd=5, rf_di=32'h1234;
//     regfile r5=32'h1234 after the negedge; pend_mask[5] is 1 for two cycles.
//  3. Both valid on the same edge, nd0=3/di=A, nd1=4/di=B, rr_ptr=0 -> r3 commits cycle+1 and
//     r4 commits cycle+2; on the next tie req1 is granted first.
//  4. Both valid on the same edge, nd0=nd1=7, di0=32'h11, di1=32'h22 -> two writes in order;
//     final r7=32'h22.
//  5. Both requesters continuously valid for 20 cycles -> 20 rf_we pulses, alternating 0/1;
//     req_ready never low two cycles running for either requester.
//  6. RF_ZERO_GUARD_EN: req0 nd=0, di=32'hFFFF with req1 nd=2 -> no rf_we for r0, r2 written
//     next cycle, r0 stays 0. Without the macro: rf_we pulses with rf_nd=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback request types.
// Both the writeback arbiter and the register file use these definitions.
package rf_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  // One register-file write: destination register and its data.
  typedef struct packed {
    logic [RF_AW-1:0] nd;
    logic [RF_DW-1:0] di;
  } wb_req_t;

  // Relative fill order of the two holding slots.
  // AGE_TIE: both slots were filled on the same edge, or fewer than two are valid.
  typedef enum logic [1:0] {
    AGE_TIE  = 2'd0,
    AGE_OLD0 = 2'd1,
    AGE_OLD1 = 2'd2
  } age_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot.
// Accepts a write whenever it is empty or being drained in the same cycle, so a
// continuously valid requester can refill it back-to-back.
// Handshake: a write transfers on the posedge where in_valid and ready are both 1.
module rf_wb_slot
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_nd,
  input  logic [DW-1:0] in_di,
  input  logic          drain,
  output logic          ready,
  output logic          hold_v,
  output logic [AW-1:0] hold_nd,
  output logic [DW-1:0] hold_di
);

  logic          hold_v_q,  hold_v_d;
  logic [AW-1:0] hold_nd_q, hold_nd_d;
  logic [DW-1:0] hold_di_q, hold_di_d;

  // Ready depends only on held state and the drain decision, never on in_valid.
  always_comb begin
    ready = !hold_v_q || drain;
  end

  // Next slot contents: a new fill wins over a drain of the old entry.
  always_comb begin
    hold_v_d  = hold_v_q;
    hold_nd_d = hold_nd_q;
    hold_di_d = hold_di_q;
    if (in_valid && ready) begin
      hold_v_d  = 1'b1;
      hold_nd_d = in_nd;
      hold_di_d = in_di;
    end else if (drain) begin
      hold_v_d  = 1'b0;
    end
  end

  // Slot registers; reset discards any held write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q  <= 1'b0;
      hold_nd_q <= '0;
      hold_di_q <= '0;
    end else begin
      hold_v_q  <= hold_v_d;
      hold_nd_q <= hold_nd_d;
      hold_di_q <= hold_di_d;
    end
  end

  assign hold_v  = hold_v_q;
  assign hold_nd = hold_nd_q;
  assign hold_di = hold_di_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one registered write port (rf_we/rf_nd/rf_di)
// between req0 (ALU/immediate) and req1 (load/multi-cycle), each with a one-entry slot.
// Grant order: the older slot first; on a same-edge fill, req0 first when both target the
// same register (so req1's value is final), otherwise round-robin.
// pend_mask flags registers with a write held or on the port and not yet committed.
// Optional feature macro RF_ZERO_GUARD_EN: writes to r0 are accepted but silently dropped,
// and pend_mask[0] stays 0.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  parameter int NREG = RF_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [AW-1:0]   req_nd0,
  input  logic [DW-1:0]   req_di0,
  input  logic [AW-1:0]   req_nd1,
  input  logic [DW-1:0]   req_di1,
  output logic            rf_we,
  output logic [AW-1:0]   rf_nd,
  output logic [DW-1:0]   rf_di,
  output logic [NREG-1:0] pend_mask
);

  logic [1:0]    hold_v;
  logic [AW-1:0] hold_nd0, hold_nd1;
  logic [DW-1:0] hold_di0, hold_di1;
  logic [1:0]    grant, drop, elig, drain, fill, next_v;

  age_t          age_q, age_d;
  logic          rr_q, rr_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_nd_q, rf_nd_d;
  logic [DW-1:0] rf_di_q, rf_di_d;

  rf_wb_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (req_valid[0]),
    .in_nd    (req_nd0),
    .in_di    (req_di0),
    .drain    (drain[0]),
    .ready    (req_ready[0]),
    .hold_v   (hold_v[0]),
    .hold_nd  (hold_nd0),
    .hold_di  (hold_di0)
  );

  rf_wb_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (req_valid[1]),
    .in_nd    (req_nd1),
    .in_di    (req_di1),
    .drain    (drain[1]),
    .ready    (req_ready[1]),
    .hold_v   (hold_v[1]),
    .hold_nd  (hold_nd1),
    .hold_di  (hold_di1)
  );

  // Held writes to r0 are discarded without using the port when the guard is built in.
  always_comb begin
`ifdef RF_ZERO_GUARD_EN
    drop[0] = hold_v[0] && (hold_nd0 == '0);
    drop[1] = hold_v[1] && (hold_nd1 == '0);
`else
    drop = 2'b00;
`endif
    elig  = hold_v & ~drop;
    drain = grant | drop;
    fill  = req_valid & req_ready;
  end

  // Pick one eligible slot: oldest first, then same-register order, then round-robin.
  always_comb begin
    grant = 2'b00;
    rr_d  = rr_q;
    case (elig)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (age_q == AGE_OLD0) begin
          grant = 2'b01;
        end else if (age_q == AGE_OLD1) begin
          grant = 2'b10;
        end else if (hold_nd0 == hold_nd1) begin
          grant = 2'b01;
        end else begin
          grant = rr_q ? 2'b10 : 2'b01;
          rr_d  = !rr_q;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  // Track which slot was filled first; only meaningful while both stay valid.
  always_comb begin
    next_v = fill | (hold_v & ~drain);
    age_d  = age_q;
    if (next_v == 2'b11) begin
      case (fill)
        2'b11:   age_d = AGE_TIE;
        2'b01:   age_d = AGE_OLD1;
        2'b10:   age_d = AGE_OLD0;
        default: age_d = age_q;
      endcase
    end else begin
      age_d = AGE_TIE;
    end
  end

  // Output stage: launch the granted write; address/data hold when idle.
  always_comb begin
    rf_we_d = |grant;
    rf_nd_d = rf_nd_q;
    rf_di_d = rf_di_q;
    if (grant[0]) begin
      rf_nd_d = hold_nd0;
      rf_di_d = hold_di0;
    end else if (grant[1]) begin
      rf_nd_d = hold_nd1;
      rf_di_d = hold_di1;
    end
  end

  // Arbiter and port registers; reset drops rf_we immediately so no partial write occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q   <= AGE_TIE;
      rr_q    <= 1'b0;
      rf_we_q <= 1'b0;
      rf_nd_q <= '0;
      rf_di_q <= '0;
    end else begin
      age_q   <= age_d;
      rr_q    <= rr_d;
      rf_we_q <= rf_we_d;
      rf_nd_q <= rf_nd_d;
      rf_di_q <= rf_di_d;
    end
  end

  // Pending-write mask decoded from both slots and the write port.
  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_mask[r] = (hold_v[0] && (hold_nd0 == AW'(r))) ||
                     (hold_v[1] && (hold_nd1 == AW'(r))) ||
                     (rf_we_q   && (rf_nd_q  == AW'(r)));
    end
`ifdef RF_ZERO_GUARD_EN
    pend_mask[0] = 1'b0;
`endif
  end

  assign rf_we = rf_we_q;
  assign rf_nd = rf_nd_q;
  assign rf_di = rf_di_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed cases plus random traffic, checked every
// cycle against a timestamp-ordered reference model and a shadow register file.
module tb_regfile_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
`ifdef RF_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [AW-1:0]   req_nd0, req_nd1;
  logic [DW-1:0]   req_di0, req_di1;
  logic            rf_we;
  logic [AW-1:0]   rf_nd;
  logic [DW-1:0]   rf_di;
  logic [NREG-1:0] pend_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_nd0   (req_nd0),
    .req_di0   (req_di0),
    .req_nd1   (req_nd1),
    .req_di1   (req_di1),
    .rf_we     (rf_we),
    .rf_nd     (rf_nd),
    .rf_di     (rf_di),
    .pend_mask (pend_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot remembers the cycle it was filled; the oldest eligible write goes first.
  bit            m_v [2];
  logic [AW-1:0] m_nd[2];
  logic [DW-1:0] m_di[2];
  int            m_ts[2];
  bit            m_rr;
  bit            m_we;
  logic [AW-1:0] m_ond;
  logic [DW-1:0] m_odi;
  int            cyc = 0;
  logic [DW-1:0] exp_rf[NREG];
  logic [DW-1:0] act_rf[NREG];

  function automatic bit m_zero(input int i);
    return m_v[i] && GUARD && (m_nd[i] == '0);
  endfunction

  function automatic int pick(output bit tog);
    bit e0, e1;
    e0  = m_v[0] && !m_zero(0);
    e1  = m_v[1] && !m_zero(1);
    tog = 1'b0;
    if (e0 && e1) begin
      if (m_ts[0] < m_ts[1]) return 0;
      if (m_ts[1] < m_ts[0]) return 1;
      if (m_nd[0] == m_nd[1]) return 0;
      tog = 1'b1;
      return m_rr ? 1 : 0;
    end
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] m_ready();
    bit t;
    int g;
    logic [1:0] r;
    g = pick(t);
    for (int i = 0; i < 2; i++) r[i] = !m_v[i] || (g == i) || m_zero(i);
    return r;
  endfunction

  function automatic logic [NREG-1:0] m_pend();
    logic [NREG-1:0] p;
    p = '0;
    for (int i = 0; i < 2; i++) if (m_v[i]) p[m_nd[i]] = 1'b1;
    if (m_we) p[m_ond] = 1'b1;
    if (GUARD) p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_nd[i] = '0; m_di[i] = '0; m_ts[i] = 0;
    end
    m_rr = 1'b0; m_we = 1'b0; m_ond = '0; m_odi = '0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [AW-1:0] nd0, input logic [DW-1:0] di0,
                            input logic [AW-1:0] nd1, input logic [DW-1:0] di1);
    int g;
    bit t;
    logic [1:0] rdy;
    bit gone[2];
    rdy = m_ready();
    g   = pick(t);
    if (t) m_rr = !m_rr;
    for (int i = 0; i < 2; i++) gone[i] = (g == i) || m_zero(i);
    if (g >= 0) begin
      m_we = 1'b1; m_ond = m_nd[g]; m_odi = m_di[g];
    end else begin
      m_we = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (v[i] && rdy[i]) begin
        m_v[i]  = 1'b1;
        m_nd[i] = (i == 0) ? nd0 : nd1;
        m_di[i] = (i == 0) ? di0 : di1;
        m_ts[i] = cyc;
      end else if (gone[i]) begin
        m_v[i] = 1'b0;
      end
    end
    cyc++;
  endtask

  // ---------------- driver ----------------
  // Called just after a posedge; drives inputs for the next edge and advances the model.
  task automatic drive(input logic [1:0] v, input logic [AW-1:0] nd0, input logic [DW-1:0] di0,
                       input logic [AW-1:0] nd1, input logic [DW-1:0] di1);
    req_valid = v; req_nd0 = nd0; req_di0 = di0; req_nd1 = nd1; req_di1 = di1;
    @(posedge clk);
    model_step(v, nd0, di0, nd1, di1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(2'b00, '0, '0, '0, '0);
  endtask

  // ---------------- scoreboard: every-cycle compare and regfile commit ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("rf_we", rf_we, m_we);
      check("rf_nd", rf_nd, m_ond);
      check("rf_di", rf_di, m_odi);
      check("pend_mask", pend_mask, m_pend());
      check("req_ready", req_ready, m_ready());
      if (rf_we) act_rf[rf_nd] = rf_di;
      if (m_we)  exp_rf[m_ond] = m_odi;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pulses, bad_ready;
    bit prev_low[2];
    logic [1:0] v;
    logic [AW-1:0] a0, a1;

    for (int r = 0; r < NREG; r++) begin
      exp_rf[r] = '0; act_rf[r] = '0;
    end
    model_reset();
    rst = 1'b1;
    req_valid = 2'b00; req_nd0 = '0; req_nd1 = '0; req_di0 = '0; req_di1 = '0;

    // Reset state
    #1;
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_nd", rf_nd, '0);
    check("reset_rf_di", rf_di, '0);
    check("reset_pend", pend_mask, '0);
    check("reset_ready", req_ready, 2'b11);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Single write from req0
    drive(2'b01, 5'd5, 32'h1234, '0, '0);
    check("t2_pend_held", pend_mask[5], 1'b1);
    check("t2_we_lat0", rf_we, 1'b0);
    drive(2'b00, '0, '0, '0, '0);
    check("t2_we", rf_we, 1'b1);
    check("t2_nd", rf_nd, 5'd5);
    check("t2_di", rf_di, 32'h1234);
    check("t2_pend_port", pend_mask[5], 1'b1);
    @(negedge clk); #1;
    check("t2_r5", act_rf[5], 32'h1234);
    drive(2'b00, '0, '0, '0, '0);
    check("t2_pend_clear", pend_mask[5], 1'b0);

    // Same-edge tie, different registers: round-robin starts at req0
    drive(2'b11, 5'd3, 32'hA, 5'd4, 32'hB);
    drive(2'b00, '0, '0, '0, '0);
    check("t3_first_nd", rf_nd, 5'd3);
    check("t3_first_di", rf_di, 32'hA);
    drive(2'b00, '0, '0, '0, '0);
    check("t3_second_nd", rf_nd, 5'd4);
    check("t3_second_di", rf_di, 32'hB);
    idle(1);
    drive(2'b11, 5'd3, 32'hC, 5'd4, 32'hD);
    drive(2'b00, '0, '0, '0, '0);
    check("t3_next_tie_req1", rf_nd, 5'd4);
    drive(2'b00, '0, '0, '0, '0);
    check("t3_next_tie_req0", rf_nd, 5'd3);
    idle(1);

    // Same-edge tie, same register: req1's value must land last
    drive(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    drive(2'b00, '0, '0, '0, '0);
    check("t4_first_di", rf_di, 32'h11);
    drive(2'b00, '0, '0, '0, '0);
    check("t4_second_di", rf_di, 32'h22);
    @(negedge clk); #1;
    check("t4_r7_final", act_rf[7], 32'h22);
    idle(1);

    // Both continuously valid: one write per cycle, alternating, no double stall
    pulses = 0; bad_ready = 0; prev_low[0] = 1'b0; prev_low[1] = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      drive(2'b11, 5'd10, DW'(k), 5'd11, DW'(100 + k));
      if (k >= 1) begin
        if (rf_we) pulses++;
        check("t5_alternate", rf_nd, (k % 2 == 1) ? 5'd10 : 5'd11);
      end
      for (int i = 0; i < 2; i++) begin
        if (!req_ready[i] && prev_low[i]) bad_ready++;
        prev_low[i] = !req_ready[i];
      end
    end
    check("t5_pulses", pulses, 20);
    check("t5_ready_double_low", bad_ready, 0);
    idle(3);

    // Write to r0 alongside r2 (round-robin now points at req1)
    drive(2'b11, 5'd0, 32'hFFFF, 5'd2, 32'h2222);
    drive(2'b00, '0, '0, '0, '0);
    check("t6_r2_we", rf_we, 1'b1);
    check("t6_r2_nd", rf_nd, 5'd2);
    check("t6_r2_di", rf_di, 32'h2222);
    drive(2'b00, '0, '0, '0, '0);
    @(negedge clk); #1;
    if (GUARD) begin
      check("t6_r0_no_we", rf_we, 1'b0);
      check("t6_r0_stays", act_rf[0], 32'h0);
    end else begin
      check("t6_r0_we", rf_we, 1'b1);
      check("t6_r0_value", act_rf[0], 32'hFFFF);
    end
    idle(1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = AW'($urandom_range(0, NREG - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, NREG - 1));
      drive(v, a0, $urandom, a1, $urandom);
    end
    idle(3);

    // Reset mid-stream with both slots full and a write on the port
    drive(2'b11, 5'd12, 32'h1200, 5'd13, 32'h1300);
    drive(2'b11, 5'd14, 32'h1400, 5'd15, 32'h1500);
    req_valid = 2'b00;
    check("t1_pre_we", rf_we, 1'b1);
    check("t1_pre_pend", pend_mask != '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_we", rf_we, 1'b0);
    check("t1_rst_pend", pend_mask, '0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    #1;
    check("t1_post_ready", req_ready, 2'b11);
    drive(2'b01, 5'd9, 32'h99, '0, '0);
    drive(2'b00, '0, '0, '0, '0);
    check("t1_post_nd", rf_nd, 5'd9);
    check("t1_post_di", rf_di, 32'h99);
    idle(2);

    // Shadow register file must match the model's commit history
    chk_en = 1'b0;
    for (int r = 0; r < NREG; r++) check($sformatf("regfile_r%0d", r), act_rf[r], exp_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
